// File: rtl/uart_cmd_fifo.sv
// rtl/uart_cmd_fifo.sv - UART receive FIFO with CPU register window, irq and direction-LED decode
// Optional feature: define RXF_CMD_FILTER_EN to keep only U/D/L/R command words.
module uart_cmd_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              cpu_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              rd_en_i,
    input  logic [1:0]        rd_addr_i,
    output logic [31:0]       rd_data_o,
    output logic              irq_o,
    output logic [3:0]        leds_o
);

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CLEAR  = 2'd2;
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count;
    logic [31:0]       rd_data_q, rd_data_d;
    logic [31:0]       status;
    logic [3:0]        leds_q, leds_d;
    logic [3:0]        led_code;
    logic [7:0]        cmd_byte;
    logic              irq_q;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              full, empty, is_cmd;
    logic              data_rd, pop_fire, push_fire, drop, udf_evt, clear;

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    assign data_rd  = rd_en_i && (rd_addr_i == A_DATA);
    assign pop_fire = data_rd && !empty;
    assign udf_evt  = data_rd && empty;
    assign clear    = rd_en_i && (rd_addr_i == A_CLEAR);

    // A pop in the same cycle frees a slot, so a full FIFO can still take a word.
    assign in_ready_o = !full || pop_fire;

    assign cmd_byte = in_data_i[7:0];

    always_comb begin
        led_code = 4'b0000;
        case (cmd_byte)
            8'h55:   led_code = 4'b0001;
            8'h44:   led_code = 4'b0010;
            8'h4C:   led_code = 4'b0100;
            8'h52:   led_code = 4'b1000;
            default: led_code = 4'b0000;
        endcase
    end

    assign is_cmd = (led_code != 4'b0000);

`ifdef RXF_CMD_FILTER_EN
    // Non-command words are consumed but never stored and never count as overflow.
    assign push_fire = in_valid_i && in_ready_o && is_cmd;
    assign drop      = in_valid_i && !in_ready_o && is_cmd;
`else
    assign push_fire = in_valid_i && in_ready_o;
    assign drop      = in_valid_i && !in_ready_o;
`endif

    assign status = {12'd0, udf_q, ovf_q, full, empty, 7'd0, 9'(count)};

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        leds_d    = leds_q;
        if (push_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            leds_d   = led_code;
        end
        if (pop_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (rd_en_i) begin
            case (rd_addr_i)
                A_DATA:   rd_data_d = pop_fire ? 32'(mem_q[rd_ptr_q[ADDR_W-1:0]]) : 32'd0;
                A_STATUS: rd_data_d = status;
                default:  rd_data_d = 32'd0;
            endcase
        end
        // A flag event coinciding with a clear keeps the flag set.
        ovf_d = drop || (ovf_q && !clear);
        udf_d = udf_evt || (udf_q && !clear);
    end

    always_ff @(posedge cpu_clk) begin
        if (push_fire) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= in_data_i;
        end
    end

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= 32'd0;
            leds_q    <= 4'b0000;
            irq_q     <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
            leds_q    <= leds_d;
            irq_q     <= !empty;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign irq_o     = irq_q;
    assign leds_o    = leds_q;

endmodule

// File: tb/tb_uart_cmd_fifo.sv
// tb/tb_uart_cmd_fifo.sv - self-checking bench for uart_cmd_fifo with a queue-based reference model
module tb_uart_cmd_fifo;

    localparam int DEPTH = 16;

    logic        cpu_clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic [31:0] rd_data;
    logic        irq;
    logic [3:0]  leds;

    uart_cmd_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .cpu_clk    (cpu_clk),
        .rst        (rst),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .rd_en_i    (rd_en),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .irq_o      (irq),
        .leds_o     (leds)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  q[$];
    logic        m_ov, m_uf, m_irq;
    logic [3:0]  m_leds;
    logic [31:0] m_rd;
    logic        rdy_seen, rdy_exp;

    function automatic logic [3:0] led_of(input logic [7:0] d);
        case (d)
            8'h55:   return 4'b0001;
            8'h44:   return 4'b0010;
            8'h4C:   return 4'b0100;
            8'h52:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic model_ready(input logic re, input logic [1:0] a);
        return (q.size() < DEPTH) || (re && a == 2'd0 && q.size() > 0);
    endfunction

    task automatic model_step(input logic v, input logic [7:0] d, input logic re, input logic [1:0] a);
        int          n;
        logic        is_full, is_empty, pop, ready, acc, drop, clr, uf_evt;
        logic [31:0] st;
        n        = q.size();
        is_full  = (n == DEPTH);
        is_empty = (n == 0);
        pop      = re && a == 2'd0 && !is_empty;
        ready    = !is_full || pop;
`ifdef RXF_CMD_FILTER_EN
        acc  = v && ready && (led_of(d) != 4'b0000);
        drop = v && !ready && (led_of(d) != 4'b0000);
`else
        acc  = v && ready;
        drop = v && !ready;
`endif
        st     = {12'd0, m_uf, m_ov, is_full, is_empty, 7'd0, 9'(n)};
        clr    = re && a == 2'd2;
        uf_evt = re && a == 2'd0 && is_empty;
        m_irq  = !is_empty;
        if (re) begin
            if (a == 2'd0) m_rd = pop ? {24'd0, q.pop_front()} : 32'd0;
            else if (a == 2'd1) m_rd = st;
            else m_rd = 32'd0;
        end
        m_ov = drop || (m_ov && !clr);
        m_uf = uf_evt || (m_uf && !clr);
        if (acc) begin
            q.push_back(d);
            m_leds = led_of(d);
        end
    endtask

    task automatic drive_cycle(input logic v, input logic [7:0] d, input logic re, input logic [1:0] a);
        in_valid = v;
        in_data  = d;
        rd_en    = re;
        rd_addr  = a;
        #1;
        rdy_seen = in_ready;
        rdy_exp  = model_ready(re, a);
        @(posedge cpu_clk);
        #1;
        model_step(v, d, re, a);
        in_valid = 1'b0;
        rd_en    = 1'b0;
    endtask

    task automatic model_clear();
        q.delete();
        m_ov = 0; m_uf = 0; m_irq = 0; m_leds = 0; m_rd = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        @(posedge cpu_clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive_cycle(1, 8'h55, 0, 0);
        drive_cycle(1, 8'h44, 0, 0);
        drive_cycle(0, 8'h00, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (leds !== 4'b0000) begin n_err++; $display("FAIL reset_leds got %b want 0000", leds); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", irq); end
        n_cmp++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        model_clear();
        @(posedge cpu_clk);
        #1;
        rst = 1'b0;
        drive_cycle(0, 8'h00, 1, 1);
        n_cmp++; if (rd_data !== 32'h0001_0000) begin n_err++; $display("FAIL reset_status got %h want 00010000", rd_data); end
    endtask

    task automatic test_order();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h55; exp_b[1] = 8'h44; exp_b[2] = 8'h52;
        for (int i = 0; i < 3; i++) drive_cycle(1, exp_b[i], 0, 0);
        n_cmp++; if (leds !== 4'b1000) begin n_err++; $display("FAIL order_leds got %b want 1000", leds); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL order_irq_high got %b want 1", irq); end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(0, 8'h00, 1, 0);
            n_cmp++; if (rd_data !== {24'd0, exp_b[i]}) begin n_err++; $display("FAIL order_pop%0d got %h want %h", i, rd_data, exp_b[i]); end
        end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL order_irq_lag got %b want 1", irq); end
        drive_cycle(0, 8'h00, 0, 0);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL order_irq_fall got %b want 0", irq); end
        n_cmp++; if (rd_data !== 32'h52) begin n_err++; $display("FAIL order_hold got %h want 00000052", rd_data); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) drive_cycle(1, 8'(i), 0, 0);
        drive_cycle(1, 8'hAA, 0, 0);
        n_cmp++; if (rdy_seen !== 1'b0) begin n_err++; $display("FAIL full_ready_on_push got %b want 0", rdy_seen); end
        drive_cycle(0, 8'h00, 1, 1);
        n_cmp++; if (rd_data !== 32'h0006_0010) begin n_err++; $display("FAIL full_status got %h want 00060010", rd_data); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        drive_cycle(1, 8'hCC, 1, 2);
        drive_cycle(0, 8'h00, 1, 1);
        n_cmp++; if (rd_data !== 32'h0006_0010) begin n_err++; $display("FAIL full_clear_race got %h want 00060010", rd_data); end
        drive_cycle(0, 8'h00, 1, 2);
        n_cmp++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL full_clear_rd got %h want 0", rd_data); end
        drive_cycle(0, 8'h00, 1, 1);
        n_cmp++; if (rd_data !== 32'h0002_0010) begin n_err++; $display("FAIL full_cleared got %h want 00020010", rd_data); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] want;
        drive_cycle(1, 8'hBB, 1, 0);
        n_cmp++; if (rdy_seen !== 1'b1) begin n_err++; $display("FAIL fpp_ready got %b want 1", rdy_seen); end
        n_cmp++; if (rd_data !== 32'h00) begin n_err++; $display("FAIL fpp_oldest got %h want 00000000", rd_data); end
        drive_cycle(0, 8'h00, 1, 1);
        n_cmp++; if (rd_data !== 32'h0002_0010) begin n_err++; $display("FAIL fpp_count got %h want 00020010", rd_data); end
        for (int i = 1; i <= 16; i++) begin
            want = (i == 16) ? 8'hBB : 8'(i);
            drive_cycle(0, 8'h00, 1, 0);
            n_cmp++; if (rd_data !== {24'd0, want}) begin n_err++; $display("FAIL fpp_pop%0d got %h want %h", i, rd_data, want); end
        end
    endtask

    task automatic test_empty_pop();
        do_reset();
        drive_cycle(0, 8'h00, 1, 1);
        drive_cycle(0, 8'h00, 1, 0);
        n_cmp++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL empty_pop_rd got %h want 0", rd_data); end
        drive_cycle(0, 8'h00, 1, 1);
        n_cmp++; if (rd_data !== 32'h0009_0000) begin n_err++; $display("FAIL empty_underflow got %h want 00090000", rd_data); end
        drive_cycle(1, 8'h44, 1, 0);
        n_cmp++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL empty_pp_rd got %h want 0", rd_data); end
        drive_cycle(0, 8'h00, 1, 1);
        n_cmp++; if (rd_data !== 32'h0008_0001) begin n_err++; $display("FAIL empty_pp_count got %h want 00080001", rd_data); end
    endtask

    task automatic test_filter();
        logic [31:0] want;
`ifdef RXF_CMD_FILTER_EN
        want = 32'h0000_0001;
`else
        want = 32'h0000_0002;
`endif
        do_reset();
        drive_cycle(1, 8'h41, 0, 0);
        drive_cycle(1, 8'h4C, 0, 0);
        drive_cycle(0, 8'h00, 1, 1);
        n_cmp++; if (rd_data !== want) begin n_err++; $display("FAIL filter_count got %h want %h", rd_data, want); end
        n_cmp++; if (leds !== 4'b0100) begin n_err++; $display("FAIL filter_leds got %b want 0100", leds); end
    endtask

    task automatic test_random();
        logic       v, re;
        logic [7:0] d;
        logic [1:0] a;
        int         push_pct;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            push_pct = ((c / 100) % 2 == 0) ? 85 : 30;
            v  = ($urandom_range(0, 99) < push_pct);
            case ($urandom_range(0, 5))
                0: d = 8'h55;
                1: d = 8'h44;
                2: d = 8'h4C;
                3: d = 8'h52;
                default: d = 8'($urandom_range(0, 255));
            endcase
            re = ($urandom_range(0, 99) < 45);
            a  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            drive_cycle(v, d, re, a);
            n_cmp++; if (rdy_seen !== rdy_exp) begin n_err++; $display("FAIL rnd_ready c%0d got %b want %b", c, rdy_seen, rdy_exp); end
            n_cmp++; if (rd_data !== m_rd) begin n_err++; $display("FAIL rnd_rd_data c%0d got %h want %h", c, rd_data, m_rd); end
            n_cmp++; if (irq !== m_irq) begin n_err++; $display("FAIL rnd_irq c%0d got %b want %b", c, irq, m_irq); end
            n_cmp++; if (leds !== m_leds) begin n_err++; $display("FAIL rnd_leds c%0d got %b want %b", c, leds, m_leds); end
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        rd_en    = 1'b0;
        rd_addr  = 2'd0;
        #1;
        do_reset();
        test_reset();
        test_order();
        test_full();
        test_full_push_pop();
        test_empty_pop();
        test_filter();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
